// File: rtl/move_commit_ctrl.sv
// move_commit_ctrl: five-in-a-row turn controller that commits a stone and drives the win-check chain.
module move_commit_ctrl #(
    parameter int CELLS       = 256,
    parameter int CHK_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       place,
    input  logic [7:0] cursor,
    input  logic       new_game,
    input  logic [1:0] board_rdata,
    output logic [7:0] board_addr,
    output logic       board_we,
    output logic [1:0] board_wdata,
    input  logic [7:0] chk_addr,
    input  logic       chk_success,
    input  logic       chk_fail,
    output logic       chk_active,
    output logic       chk_reset,
    output logic [7:0] pointer,
    output logic [1:0] chess,
    output logic [1:0] player,
    output logic [1:0] winner,
    output logic       game_over,
    output logic       busy,
    output logic       reject,
    output logic [8:0] move_count,
    output logic       timeout_err
);
    localparam int WDW = $clog2(CHK_TIMEOUT + 1);
    typedef enum logic [3:0] {CLEAR, IDLE, RD, OCC, WRITE, ARM, CHECK, DONE, OVER} state_t;
    state_t state, next_state;
    logic [7:0] clear_cnt;
    logic [WDW-1:0] wd;
    logic wd_hit, full, restart;
    assign wd_hit  = wd == WDW'(CHK_TIMEOUT - 1);
    assign full    = move_count == 9'(CELLS);
    assign restart = (state == IDLE || state == OVER) && new_game;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= CLEAR;
        else state <= next_state;
    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   next_state = clear_cnt == 8'hff ? IDLE : CLEAR;
            IDLE:    next_state = new_game ? CLEAR : place ? RD : IDLE;
            RD:      next_state = OCC;
            OCC:     next_state = board_rdata != 2'd0 ? IDLE : WRITE;
            WRITE:   next_state = ARM;
            ARM:     next_state = CHECK;
            CHECK:   next_state = chk_success ? OVER : chk_fail ? (full ? OVER : DONE) : wd_hit ? DONE : CHECK;
            DONE:    next_state = IDLE;
            OVER:    next_state = new_game ? CLEAR : OVER;
            default: next_state = CLEAR;
        endcase
    end
    always_comb begin
        board_addr  = state == CLEAR ? clear_cnt : state == CHECK ? chk_addr : pointer;
        board_we    = state == CLEAR || state == WRITE;
        board_wdata = state == WRITE ? chess : 2'd0;
        chk_active  = state == ARM;
        game_over   = state == OVER;
        busy        = !(state == IDLE || state == OVER);
    end
    // chk_reset is decoded from next_state so the registered copy lines up with the state it belongs to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_cnt   <= 8'd0;
            player      <= 2'd1;
            winner      <= 2'd0;
            move_count  <= 9'd0;
            pointer     <= 8'd0;
            chess       <= 2'd0;
            reject      <= 1'b0;
            timeout_err <= 1'b0;
            chk_reset   <= 1'b1;
            wd          <= '0;
        end else begin
            clear_cnt <= state == CLEAR ? clear_cnt + 8'd1 : 8'd0;
            chk_reset <= !(next_state == ARM || next_state == CHECK);
            reject    <= (place && state != IDLE) || (state == OCC && board_rdata != 2'd0);
            wd        <= state == CHECK ? wd + 1'b1 : '0;
            if (state == IDLE && !new_game && place) begin
                pointer <= cursor;
                chess   <= player;
            end
            if (state == WRITE) move_count <= move_count + 9'd1;
            if (restart) begin
                winner     <= 2'd0;
                player     <= 2'd1;
                move_count <= 9'd0;
            end
            if (state == CHECK) begin
                if (chk_success) winner <= chess;
                else if (chk_fail && !full) player <= player ^ 2'b11;
                else if (!chk_fail && wd_hit) timeout_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_move_commit_ctrl.sv
// tb_move_commit_ctrl: directed and randomized moves checked against a board-level game model.
module tb_move_commit_ctrl;
    logic       clk = 0, reset = 1, place = 0, new_game = 0, chk_success = 0, chk_fail = 0;
    logic [7:0] cursor = 0, chk_addr = 0;
    logic [1:0] board_rdata = 0;
    logic [7:0] board_addr, pointer;
    logic       board_we, chk_active, chk_reset, game_over, busy, reject, timeout_err;
    logic [1:0] board_wdata, chess, player, winner;
    logic [8:0] move_count;
    logic [1:0] mem [256];
    int checks = 0, errors = 0;
    int mboard [256];
    int mplayer, mmoves, mwinner, mover, mtimeout;
    logic [7:0] placed [$];

    move_commit_ctrl dut (
        .clk(clk), .reset(reset), .place(place), .cursor(cursor), .new_game(new_game),
        .board_rdata(board_rdata), .board_addr(board_addr), .board_we(board_we),
        .board_wdata(board_wdata), .chk_addr(chk_addr), .chk_success(chk_success),
        .chk_fail(chk_fail), .chk_active(chk_active), .chk_reset(chk_reset),
        .pointer(pointer), .chess(chess), .player(player), .winner(winner),
        .game_over(game_over), .busy(busy), .reject(reject), .move_count(move_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // board RAM with registered read
    always @(posedge clk) begin
        if (board_we) mem[board_addr] <= board_wdata;
        board_rdata <= mem[board_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mreset();
        for (int i = 0; i < 256; i++) mboard[i] = 0;
        placed.delete();
        mplayer = 1; mmoves = 0; mwinner = 0; mover = 0;
    endtask

    task automatic sweep(input int start);
        logic ok;
        ok = 1;
        for (int i = start; i < 256; i++) begin
            ok &= board_we && board_addr == 8'(i) && board_wdata == 2'd0;
            step();
        end
        chk("clear_sweep", ok, 1);
        chk("clear_done_we", board_we, 0);
        chk("clear_done_busy", busy, 0);
        chk("clear_player", player, mplayer);
        chk("clear_moves", move_count, mmoves);
    endtask

    task automatic restart();
        new_game = 1;
        step();
        new_game = 0;
        mreset();
        sweep(0);
    endtask

    // resp: 0 = all directions fail, 1 = win, 2 = checker never answers
    task automatic do_move(input logic [7:0] c, input int resp);
        logic rej;
        rej = mboard[c] != 0;
        place = 1; cursor = c;
        step();
        place = 0; cursor = 8'($urandom);
        chk("busy_rd", busy, 1);
        step();
        step();
        chk("reject", reject, rej);
        if (rej) begin
            chk("reject_no_we", board_we, 0);
        end else begin
            chk("write_we", board_we, 1);
            chk("write_addr", board_addr, c);
            chk("write_data", board_wdata, mplayer);
            mboard[c] = mplayer; mmoves++; placed.push_back(c);
            step();
            chk("arm_active_rst", {chk_active, chk_reset}, 2'b10);
            chk("arm_pointer", pointer, c);
            chk("arm_chess", chess, mplayer);
            chk("arm_moves", move_count, mmoves);
            step();
            chk("check_active_low", {chk_active, chk_reset}, 2'b00);
            chk_addr = 8'($urandom);
            #1 chk("check_addr_mux", board_addr, chk_addr);
            if (resp == 2) begin
                repeat (1022) step();
                chk("wd_early", timeout_err, mtimeout);
                step();
                mtimeout = 1;
                chk("wd_fire", timeout_err, 1);
                chk("wd_player", player, mplayer);
                chk("wd_done_rst", chk_reset, 1);
                step();
            end else begin
                chk_success = resp == 1;
                chk_fail = resp == 0 || $urandom_range(1) == 1;
                step();
                chk_success = 0; chk_fail = 0;
                if (resp == 1) begin mwinner = mplayer; mover = 1; end
                else if (mmoves == 256) mover = 1;
                else mplayer = 3 - mplayer;
                chk("player", player, mplayer);
                chk("winner", winner, mwinner);
                chk("game_over", game_over, mover);
                chk("post_check_rst", chk_reset, 1);
                if (mover == 0) step();
            end
        end
        chk("idle_busy", busy, 0);
        chk("move_count", move_count, mmoves);
    endtask

    initial begin
        logic [7:0] c;
        mtimeout = 0;
        mreset();
        repeat (3) step();
        chk("rst_player", player, 1);
        chk("rst_winner", winner, 0);
        chk("rst_moves", move_count, 0);
        chk("rst_ptr_chess", {pointer, chess}, 0);
        chk("rst_flags", {chk_active, chk_reset, reject, timeout_err}, 4'b0100);
        reset = 0;
        sweep(0);
        // first legal move, then the same occupied cell
        do_move(8'h77, 0);
        do_move(8'h77, 0);
        chk("occ_player", player, 2);
        // place during the clear sweep is refused
        new_game = 1;
        step();
        new_game = 0;
        mreset();
        place = 1;
        step();
        place = 0;
        chk("reject_busy", reject, 1);
        sweep(1);
        // black builds 0x30..0x34, white plays 0x40..0x43
        for (int i = 0; i < 4; i++) begin
            do_move(8'h30 + 8'(i), 0);
            do_move(8'h40 + 8'(i), 0);
        end
        do_move(8'h34, 1);
        chk("win_winner", winner, 1);
        place = 1; cursor = 8'h00;
        step();
        place = 0;
        chk("reject_over", reject, 1);
        chk("over_hold", game_over, 1);
        restart();
        chk("restart_winner", winner, 0);
        // randomized play
        for (int n = 0; n < 80; n++) begin
            if (mover != 0) restart();
            c = (placed.size() > 0 && $urandom_range(3) == 0) ? placed[$urandom_range(placed.size() - 1)] : 8'($urandom);
            do_move(c, $urandom_range(15) == 0 ? 1 : 0);
        end
        if (mover != 0) restart();
        // watchdog
        c = 8'($urandom);
        while (mboard[c] != 0) c++;
        do_move(c, 2);
        chk("wd_sticky", timeout_err, 1);
        // reset while in CHECK
        c = 8'($urandom);
        while (mboard[c] != 0) c++;
        place = 1; cursor = c;
        step();
        place = 0;
        repeat (4) step();
        chk("pre_reset_check", {busy, chk_reset}, 2'b10);
        reset = 1;
        #1;
        chk("async_clear", {board_we, board_addr, board_wdata}, {1'b1, 8'h00, 2'd0});
        chk("async_chk_reset", chk_reset, 1);
        chk("async_moves", move_count, 0);
        chk("async_timeout", timeout_err, 0);
        step();
        reset = 0;
        mreset();
        mtimeout = 0;
        sweep(0);
        do_move(c, 0);
        // draw by filling every cell
        restart();
        for (int i = 0; i < 256; i++) do_move(8'(i), 0);
        chk("draw_over", game_over, 1);
        chk("draw_winner", winner, 0);
        chk("draw_moves", move_count, 256);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/move_commit_ctrl.md
Name: move_commit_ctrl

Overview:
- Turn and move controller for the 16x16 five-in-a-row board; sits directly upstream of the four-stage win-check chain (horizontal -> vertical -> diagonal -> anti-diagonal).
- Accepts a placement request at the cursor and checks that the cell is empty. If so, it writes the current player's stone into board memory, then launches the check chain with pointer/chess.
- Arbitrates the single board-memory port between itself and the chain, resolves win/continue, and alternates turns. After reset or new_game it clears the board.

Parameters:
- CELLS, 256, number of board cells; addresses are {row[3:0], col[3:0]}.
- CHK_TIMEOUT, 1023, maximum cycles in CHECK before the watchdog fires.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- place  in  1  single-cycle placement request
- cursor  in  8  target cell {row, col}
- new_game  in  1  single-cycle request to clear the board and restart
- board_rdata  in  2  board read data; registered read, 1-cycle latency
- board_addr  out  8  board address (combinational mux)
- board_we  out  1  board write enable
- board_wdata  out  2  board write data
- chk_addr  in  8  read address driven by the active checker
- chk_success  in  1  OR of all four checker success outputs
- chk_fail  in  1  active_next of the last checker (all four directions failed)
- chk_active  out  1  start pulse to the first checker
- chk_reset  out  1  reset to all checkers
- pointer  out  8  latched move address for the checkers
- chess  out  2  latched stone code for the checkers
- player  out  2  side to move: 1 = black, 2 = white
- winner  out  2  0 = none, 1 = black, 2 = white
- game_over  out  1  high in OVER
- busy  out  1  high in any state except IDLE and OVER
- reject  out  1  1-cycle pulse when a request is refused
- move_count  out  9  stones placed this game
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Cell codes: 0 empty, 1 black, 2 white.
- Reset values: state = CLEAR, clear_cnt = 0, player = 1, winner = 0, move_count = 0, pointer = 0, chess = 0, chk_active = 0, reject = 0, timeout_err = 0, chk_reset = 1.
- board_addr mux:
  - CLEAR: clear_cnt.
  - RD and WRITE: pointer.
  - CHECK: chk_addr.
  - Otherwise: pointer.
- board_we is high only in CLEAR and WRITE. board_wdata is 0 in CLEAR and chess in WRITE.
- FSM states and transitions:
  - CLEAR: write 0 at clear_cnt and increment each cycle. clear_cnt is 8 bits, so it wraps from 255 to 0. Go to IDLE after writing address 255, which takes exactly 256 cycles. chk_reset stays high throughout.
  - IDLE: on place, latch pointer = cursor and chess = player, then go to RD. On new_game, go to CLEAR. If place and new_game are both high, new_game wins.
  - RD: address = pointer; go to OCC.
  - OCC: sample board_rdata. If nonzero, pulse reject and return to IDLE with no write. If zero, go to WRITE.
  - WRITE: write one cycle; increment move_count; go to ARM.
  - ARM: chk_reset = 0; pulse chk_active for 1 cycle; clear the watchdog; go to CHECK.
  - CHECK: wait for a result, incrementing the watchdog each cycle. chk_success has priority over chk_fail if both are high.
    - chk_success: set winner = chess and go to OVER.
    - chk_fail with move_count == 256: draw, winner = 0, go to OVER.
    - chk_fail otherwise: toggle player (1 <-> 2), then go to DONE.
    - Watchdog reaches CHK_TIMEOUT: set timeout_err, leave player unchanged, go to DONE.
  - DONE: chk_reset = 1 for one cycle; go to IDLE.
  - OVER: chk_reset = 1. Hold until new_game, which clears winner, resets player = 1 and move_count = 0, and goes to CLEAR.
- Request handling:
  - place while busy or in OVER: pulse reject; the request is ignored.
  - new_game while busy: deferred. It is taken on the next IDLE or OVER entry only if it is still asserted.
- Latency: an accepted legal move reaches CHECK 4 cycles after the place edge (RD, OCC, WRITE, ARM).
- Reset mid-operation: asynchronously returns to CLEAR with the reset values above. Any stone half-written is cleared by the sweep.
- chk_reset is a registered output, so it is glitch-free.

Test Plan:
- Release reset -> board_we high for exactly 256 cycles with addresses 0x00..0xFF and wdata = 0; then busy = 0, player = 1.
- place with cursor = 0x77 -> write of 1 at 0x77 on the 3rd cycle after place; chk_active pulse with pointer = 0x77 and chess = 1; on chk_fail, player = 2 and move_count = 1.
- place at an occupied cell 0x77 -> reject pulse; no board_we; player and move_count unchanged.
- Black stones at 0x30..0x33, then black places 0x34 and chk_success is asserted -> winner = 1, game_over = 1; a later place gives reject.
- Assert reset during CHECK -> state returns to CLEAR immediately, chk_reset = 1, move_count = 0.
- Hold chk_success and chk_fail at 0 in CHECK -> timeout_err = 1 after 1023 cycles, player unchanged, return to IDLE.
